// File: rtl/alu_seq.sv
// Registered ALU with single-cycle logic/arith ops and an iterative shift-add multiplier.
// A start/busy/done handshake fronts the datapath; result and NZCV flags update with done.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

   state_t             state, state_nxt;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;

   logic [WIDTH-1:0]   res_c;
   logic               c_c, v_c;
   logic [WIDTH:0]     sum, diff, shl_w, shr_w;
   logic [SHW-1:0]     amt;
   logic               big;
   logic [WIDTH-1:0]   mcand_sh;
   logic [2*WIDTH-1:0] partial;
   logic               mul_last;

   assign mul_last = (cnt == CW'(WIDTH));
   assign busy     = (state == EXEC) || (state == MUL);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = (op == OP_MUL) ? MUL : EXEC;
         EXEC: state_nxt = DONE;
         MUL:  if (mul_last) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operands stay latched through DONE, so the ALU is evaluated there and
   // result/flags land on the same edge that raises done.
   always_comb begin
      sum   = {1'b0, a_q} + {1'b0, b_q};
      diff  = {1'b0, a_q} - {1'b0, b_q};
      amt   = b_q[SHW-1:0];
      big   = (b_q >= WIDTH'(WIDTH));
      shl_w = {1'b0, a_q} << amt;
      shr_w = {a_q, 1'b0} >> amt;
      res_c = '0;
      c_c   = 1'b0;
      v_c   = 1'b0;
      case (op_q)
         OP_ADD: begin
            res_c = sum[WIDTH-1:0];
            c_c   = sum[WIDTH];
            v_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_c[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            res_c = diff[WIDTH-1:0];
            c_c   = diff[WIDTH];
            v_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_c[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND: res_c = a_q & b_q;
         OP_OR:  res_c = a_q | b_q;
         OP_XOR: res_c = a_q ^ b_q;
         OP_SHL: if (!big) begin
            res_c = shl_w[WIDTH-1:0];
            c_c   = shl_w[WIDTH];
         end
         OP_SHR: if (!big) begin
            res_c = shr_w[WIDTH:1];
            c_c   = shr_w[0];
         end
         OP_MUL: begin
            res_c = acc[WIDTH-1:0];
            c_c   = |acc[2*WIDTH-1:WIDTH];
            v_c   = c_c;
         end
         default: ;
      endcase
   end

   always_comb begin
      mcand_sh = a_q >> cnt;
      partial  = {{WIDTH{1'b0}}, b_q} << cnt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
         flags  <= 4'b0100;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               op_q <= op;
               a_q  <= operand1;
               b_q  <= operand2;
               acc  <= '0;
               cnt  <= '0;
            end
            MUL: if (!mul_last) begin
               if (mcand_sh[0]) acc <= acc + partial;
               cnt <= cnt + 1'b1;
            end
            DONE: begin
               result <= res_c;
               flags  <= {res_c[WIDTH-1], (res_c == '0), c_c, v_c};
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed corner cases plus random ops checked
// against an integer-arithmetic reference model.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = '0;
   logic [W-1:0] operand1 = '0;
   logic [W-1:0] operand2 = '0;
   logic         busy, done;
   logic [W-1:0] result;
   logic [3:0]   flags;

   int total = 0;
   int bad   = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .operand1(operand1), .operand2(operand2),
      .busy(busy), .done(done), .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   // Reference: {flags, result} from plain integer arithmetic.
   function automatic logic [11:0] model(input logic [2:0] o, input int a, input int b);
      int r, c, v, p, sa, sb, ss;
      r = 0; c = 0; v = 0;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      case (o)
         3'd0: begin p = a + b; r = p % 256; c = (p > 255); ss = sa + sb; v = (ss > 127 || ss < -128); end
         3'd1: begin r = (a - b + 256) % 256; c = (a < b); ss = sa - sb; v = (ss > 127 || ss < -128); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: if (b < W) begin r = (a << b) % 256; c = (b == 0) ? 0 : (a >> (W - b)) & 1; end
         3'd6: if (b < W) begin r = a >> b; c = (b == 0) ? 0 : (a >> (b - 1)) & 1; end
         default: begin p = a * b; r = p % 256; c = (p > 255); v = c; end
      endcase
      return {(r > 127) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, c[0], v[0], r[7:0]};
   endfunction

   // Issue one op and wait for done; lat = edges after the start edge (-1 on timeout).
   task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [7:0] r, output logic [3:0] f);
      @(negedge clk);
      start = 1'b1; op = o; operand1 = a; operand2 = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); operand1 = 8'($urandom); operand2 = 8'($urandom);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) begin lat = k; break; end
      end
      r = result; f = flags;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({busy, done, result, flags} !== {1'b0, 1'b0, 8'h00, 4'b0100}) begin
         bad++;
         $display("FAIL reset_state: got busy=%b done=%b res=%h flg=%b want 0 0 00 0100", busy, done, result, flags);
      end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_add();
      int lat; logic [7:0] r; logic [3:0] f;
      run_op(3'd0, 8'h7F, 8'h01, lat, r, f);
      total++;
      if ({r, f} !== {8'h80, 4'b1001}) begin
         bad++; $display("FAIL add_7f_01: got %h/%b want 80/1001", r, f);
      end
      total++;
      if (lat !== 2) begin bad++; $display("FAIL add_latency: got %0d want 2", lat); end
   endtask

   task automatic test_sub();
      int lat; logic [7:0] r; logic [3:0] f;
      run_op(3'd1, 8'h05, 8'h07, lat, r, f);
      total++;
      if ({r, f} !== {8'hFE, 4'b1010}) begin
         bad++; $display("FAIL sub_05_07: got %h/%b want fe/1010", r, f);
      end
      run_op(3'd1, 8'h33, 8'h33, lat, r, f);
      total++;
      if ({r, f} !== {8'h00, 4'b0100}) begin
         bad++; $display("FAIL sub_33_33: got %h/%b want 00/0100", r, f);
      end
   endtask

   task automatic test_mul();
      int lat; logic [7:0] r; logic [3:0] f;
      run_op(3'd7, 8'h10, 8'h10, lat, r, f);
      total++;
      if ({r, f} !== {8'h00, 4'b0111}) begin
         bad++; $display("FAIL mul_10_10: got %h/%b want 00/0111", r, f);
      end
      total++;
      if (lat !== W + 2) begin bad++; $display("FAIL mul_latency: got %0d want %0d", lat, W + 2); end
      run_op(3'd7, 8'h0C, 8'h0B, lat, r, f);
      total++;
      if ({r, f} !== {8'h84, 4'b1000}) begin
         bad++; $display("FAIL mul_0c_0b: got %h/%b want 84/1000", r, f);
      end
   endtask

   task automatic test_shift();
      int lat; logic [7:0] r; logic [3:0] f;
      run_op(3'd5, 8'h81, 8'd1, lat, r, f);
      total++;
      if ({r, f} !== {8'h02, 4'b0010}) begin
         bad++; $display("FAIL shl_81_1: got %h/%b want 02/0010", r, f);
      end
      run_op(3'd6, 8'h81, 8'd0, lat, r, f);
      total++;
      if ({r, f} !== {8'h81, 4'b1000}) begin
         bad++; $display("FAIL shr_81_0: got %h/%b want 81/1000", r, f);
      end
      run_op(3'd5, 8'hFF, 8'd9, lat, r, f);
      total++;
      if ({r, f} !== {8'h00, 4'b0100}) begin
         bad++; $display("FAIL shl_by_9: got %h/%b want 00/0100", r, f);
      end
   endtask

   // start hammered during a MUL (and during its DONE cycle) must be ignored.
   task automatic test_ignore_start();
      int lat, ndone, unstable;
      logic [7:0] r0; logic [3:0] f0;
      @(negedge clk);
      start = 1'b1; op = 3'd7; operand1 = 8'h0C; operand2 = 8'h0B;
      @(posedge clk); #1;
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         start = 1'b1; op = 3'($urandom); operand1 = 8'($urandom); operand2 = 8'($urandom);
         @(posedge clk); #1;
         if (done) begin lat = k; break; end
      end
      start = 1'b0;
      r0 = result; f0 = flags;
      total++;
      if (lat !== W + 2) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, W + 2); end
      total++;
      if ({r0, f0} !== {8'h84, 4'b1000}) begin
         bad++; $display("FAIL ignore_result: got %h/%b want 84/1000", r0, f0);
      end
      ndone = 0; unstable = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
         if ({result, flags} !== {r0, f0}) unstable++;
      end
      total++;
      if (ndone !== 0) begin bad++; $display("FAIL ignore_extra_activity: got %0d cycles want 0", ndone); end
      total++;
      if (unstable !== 0) begin bad++; $display("FAIL ignore_hold: got %0d changed cycles want 0", unstable); end
   endtask

   task automatic test_reset_mid_mul();
      int ndone, lat; logic [7:0] r; logic [3:0] f;
      @(negedge clk);
      start = 1'b1; op = 3'd7; operand1 = 8'hFF; operand2 = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      total++;
      if ({busy, done, result, flags} !== {1'b0, 1'b0, 8'h00, 4'b0100}) begin
         bad++;
         $display("FAIL reset_mid_mul: got busy=%b done=%b res=%h flg=%b want 0 0 00 0100", busy, done, result, flags);
      end
      @(negedge clk); reset = 1'b1;
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      total++;
      if (ndone !== 0) begin bad++; $display("FAIL reset_no_done: got %0d active cycles want 0", ndone); end
      run_op(3'd0, 8'h01, 8'h02, lat, r, f);
      total++;
      if ({r, f, lat} !== {8'h03, 4'b0000, 32'sd2}) begin
         bad++; $display("FAIL post_reset_add: got %h/%b lat=%0d want 03/0000 lat=2", r, f, lat);
      end
   endtask

   // Back-to-back random ops, each issued as soon as the previous done is seen.
   task automatic test_random();
      int lat; logic [7:0] r, a, b; logic [3:0] f; logic [2:0] o; logic [11:0] exp;
      for (int i = 0; i < 60; i++) begin
         o = 3'($urandom_range(0, 7));
         a = 8'($urandom);
         b = (o == 3'd5 || o == 3'd6) && ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
         exp = model(o, int'(a), int'(b));
         run_op(o, a, b, lat, r, f);
         total++;
         if ({f, r} !== exp || lat !== ((o == 3'd7) ? W + 2 : 2)) begin
            bad++;
            $display("FAIL random op=%0d a=%h b=%h: got %h/%b lat=%0d want %h/%b lat=%0d",
                     o, a, b, r, f, lat, exp[7:0], exp[11:8], (o == 3'd7) ? W + 2 : 2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_shift();
      test_ignore_start();
      test_reset_mid_mul();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
